// File: rtl/vga_pkg.sv
// Shared raster constants and coordinate type for the video pipeline.
package vga_pkg;

  // Horizontal and vertical screen coordinate, shared with all sprite renderers.
  typedef logic [9:0] coord_t;

  // Default 640x480 @ 60 Hz timing (pixels / lines).
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Half-open interval test: lo <= value < hi.
  function automatic logic in_range(input int value, input int lo, input int hi);
    return (value >= lo) && (value < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: counts 0..MODULUS-1 on enable and flags the wrap.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int MODULUS = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [9:0] cnt,
  output logic       carry
);

  localparam coord_t LAST = coord_t'(MODULUS - 1);

  coord_t cnt_reg;
  coord_t cnt_next;

  // Carry marks the enabled step that takes the count from LAST back to zero.
  assign carry = en && (cnt_reg == LAST);
  assign cnt   = cnt_reg;

  // Next count: advance on enable, wrapping after the last position.
  always_comb begin
    cnt_next = cnt_reg;
    if (en) begin
      cnt_next = carry ? '0 : cnt_reg + coord_t'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster scan generator: pixel divider, h/v counters, registered sync/visible decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV         = 2,
  parameter int H_VISIBLE       = H_VISIBLE_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_VISIBLE       = V_VISIBLE_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       pix_stb,
  output logic       visible,
  output logic [9:0] col,
  output logic [9:0] row,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Level driven on hsync/vsync outside the sync pulse.
  localparam logic SYNC_IDLE = (SYNC_ACTIVE_LOW != 0);

  // Coordinates are 10 bits wide, so neither axis may exceed 1024 positions.
  if (H_TOTAL > 1024) begin : g_bad_h_total
    $fatal(1, "vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_bad_v_total
    $fatal(1, "vga_timing_gen: V_TOTAL exceeds 1024");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $fatal(1, "vga_timing_gen: CLK_DIV must be at least 1");
  end

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             tick;

  coord_t h_cnt;
  coord_t v_cnt;
  logic   h_carry;
  logic   v_carry_unused;

  logic visible_next;
  logic hsync_next;
  logic vsync_next;
  logic line_start_next;
  logic frame_start_next;

  logic   pix_stb_reg;
  logic   visible_reg;
  coord_t col_reg;
  coord_t row_reg;
  logic   hsync_reg;
  logic   vsync_reg;
  logic   line_start_reg;
  logic   frame_start_reg;

  // With CLK_DIV=1 the divider sits at zero and the tick is permanently high.
  assign tick = (div_reg == DIV_LAST);

  // Divider next state: wrap after the tick position.
  always_comb begin
    div_next = tick ? '0 : div_reg + DIV_W'(1);
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
    end else begin
      div_reg <= div_next;
    end
  end

  vga_axis_counter #(
    .MODULUS(H_TOTAL)
  ) u_h_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (tick),
    .cnt  (h_cnt),
    .carry(h_carry)
  );

  // The vertical axis steps on the same edge that wraps the horizontal one.
  vga_axis_counter #(
    .MODULUS(V_TOTAL)
  ) u_v_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (h_carry),
    .cnt  (v_cnt),
    .carry(v_carry_unused)
  );

  // Decode of the current counter position, loaded into the outputs on a tick.
  always_comb begin
    visible_next     = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
    hsync_next       = in_range(int'(h_cnt), H_SYNC_START, H_SYNC_END) ? ~SYNC_IDLE : SYNC_IDLE;
    vsync_next       = in_range(int'(v_cnt), V_SYNC_START, V_SYNC_END) ? ~SYNC_IDLE : SYNC_IDLE;
    line_start_next  = (h_cnt == '0);
    frame_start_next = (h_cnt == '0) && (v_cnt == '0);
  end

  // Output registers: load on tick, strobes drop on every other clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_stb_reg     <= 1'b0;
      visible_reg     <= 1'b0;
      col_reg         <= '0;
      row_reg         <= '0;
      hsync_reg       <= SYNC_IDLE;
      vsync_reg       <= SYNC_IDLE;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else if (tick) begin
      pix_stb_reg     <= 1'b1;
      visible_reg     <= visible_next;
      col_reg         <= h_cnt;
      row_reg         <= v_cnt;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
    end else begin
      pix_stb_reg     <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end
  end

  assign pix_stb     = pix_stb_reg;
  assign visible     = visible_reg;
  assign col         = col_reg;
  assign row         = row_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: three timing configurations, random run lengths with async resets.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic   pix_stb;
    coord_t col;
    coord_t row;
    logic   visible;
    logic   hsync;
    logic   vsync;
    logic   line_start;
    logic   frame_start;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  bit done[3];

  logic   rst_n_v[3];
  logic   pix_stb_v[3];
  logic   visible_v[3];
  coord_t col_v[3];
  coord_t row_v[3];
  logic   hsync_v[3];
  logic   vsync_v[3];
  logic   line_start_v[3];
  logic   frame_start_v[3];

  // Reference: the idx-th pixel after reset, from raster arithmetic on a linear index.
  function automatic obs_t model(input int idx, input int hv, input int hf, input int hs,
                                 input int hb, input int vv, input int vf, input int vs,
                                 input int vb, input int sal);
    obs_t o;
    int ht, vt, p, c, r;
    logic h_act, v_act;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    p = idx % (ht * vt);
    c = p % ht;
    r = p / ht;
    h_act = (c >= hv + hf) && (c < hv + hf + hs);
    v_act = (r >= vv + vf) && (r < vv + vf + vs);
    o.pix_stb     = 1'b1;
    o.col         = coord_t'(c);
    o.row         = coord_t'(r);
    o.visible     = (c < hv) && (r < vv);
    o.hsync       = (sal != 0) ? ~h_act : h_act;
    o.vsync       = (sal != 0) ? ~v_act : v_act;
    o.line_start  = (c == 0);
    o.frame_start = (p == 0);
    return o;
  endfunction

  function automatic obs_t reset_obs(input int sal);
    obs_t o;
    o = '0;
    o.hsync = (sal != 0);
    o.vsync = (sal != 0);
    return o;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dut
      // 0: default timing, CLK_DIV=2; 1: default timing, CLK_DIV=1, active-high syncs;
      // 2: miniature timing, CLK_DIV=3, so whole frames fit in a short run.
      localparam int CD  = (gi == 0) ? 2 : (gi == 1) ? 1 : 3;
      localparam int HV  = (gi == 2) ? 20 : 640;
      localparam int HF  = (gi == 2) ? 3 : 16;
      localparam int HS  = (gi == 2) ? 4 : 96;
      localparam int HB  = (gi == 2) ? 5 : 48;
      localparam int VV  = (gi == 2) ? 12 : 480;
      localparam int VF  = (gi == 2) ? 2 : 10;
      localparam int VS  = 2;
      localparam int VB  = (gi == 2) ? 3 : 33;
      localparam int SAL = (gi == 1) ? 0 : 1;
      localparam int HT  = HV + HF + HS + HB;
      localparam int VT  = VV + VF + VS + VB;
      // First run crosses the (HT-1,10)->(0,11) wrap, or two full frames for the mini timing.
      localparam int FIRST_K = (gi == 2) ? (2 * HT * VT + 40) : (HT * 11 + 5);
      localparam int RAND_K  = (gi == 0) ? 2000 : (gi == 1) ? 3000 : 1500;

      vga_timing_gen #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACTIVE_LOW(SAL)
      ) dut (
        .clk        (clk),
        .rst_n      (rst_n_v[gi]),
        .pix_stb    (pix_stb_v[gi]),
        .visible    (visible_v[gi]),
        .col        (col_v[gi]),
        .row        (row_v[gi]),
        .hsync      (hsync_v[gi]),
        .vsync      (vsync_v[gi]),
        .line_start (line_start_v[gi]),
        .frame_start(frame_start_v[gi])
      );

      obs_t exp_q[$];
      obs_t got;
      assign got = {pix_stb_v[gi], col_v[gi], row_v[gi], visible_v[gi], hsync_v[gi],
                    vsync_v[gi], line_start_v[gi], frame_start_v[gi]};

      // Monitor: pop and compare on every pixel strobe, check strobe spacing and idle levels.
      initial begin
        int clk_cnt;
        int pix_seen;
        obs_t e;
        clk_cnt  = 0;
        pix_seen = 0;
        forever begin
          @(negedge clk);
          if (!rst_n_v[gi]) begin
            clk_cnt  = 0;
            pix_seen = 0;
          end else begin
            clk_cnt++;
            if (got.pix_stb) begin
              n_chk++;
              if (clk_cnt != (pix_seen + 1) * CD) begin
                n_err++;
                $display("FAIL g%0d pix_time: pixel %0d at clock %0d, required clock %0d",
                         gi, pix_seen, clk_cnt, (pix_seen + 1) * CD);
              end
              n_chk++;
              if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL g%0d extra_pix: unexpected strobe col=%0d row=%0d", gi,
                         got.col, got.row);
              end else begin
                e = exp_q.pop_front();
                if (got != e) begin
                  n_err++;
                  $display("FAIL g%0d pixel %0d: got col=%0d row=%0d vis=%b hs=%b vs=%b ls=%b fs=%b, required col=%0d row=%0d vis=%b hs=%b vs=%b ls=%b fs=%b",
                           gi, pix_seen, got.col, got.row, got.visible, got.hsync, got.vsync,
                           got.line_start, got.frame_start, e.col, e.row, e.visible, e.hsync,
                           e.vsync, e.line_start, e.frame_start);
                end
              end
              pix_seen++;
            end else begin
              n_chk++;
              if (pix_seen == 0) begin
                if (got != reset_obs(SAL)) begin
                  n_err++;
                  $display("FAIL g%0d pre_tick: got %h, required reset value %h", gi, got,
                           reset_obs(SAL));
                end
              end else if (got.line_start || got.frame_start) begin
                n_err++;
                $display("FAIL g%0d idle_strobe: ls=%b fs=%b without pix_stb, required 0", gi,
                         got.line_start, got.frame_start);
              end
            end
          end
        end
      end

      // Stimulus: release reset, push the expected pixels, run, then reset mid-scan.
      initial begin
        rst_n_v[gi] = 1'b0;
        done[gi]    = 1'b0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
          int k;
          k = (s == 0) ? FIRST_K : int'($urandom_range(1, RAND_K));
          @(negedge clk);
          #1;
          for (int i = 0; i < k; i++) begin
            exp_q.push_back(model(i, HV, HF, HS, HB, VV, VF, VS, VB, SAL));
          end
          rst_n_v[gi] = 1'b1;
          repeat (k * CD) @(posedge clk);
          @(negedge clk);
          #1;
          n_chk++;
          if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL g%0d missing_pix: %0d expected pixels not seen, required 0", gi,
                     exp_q.size());
          end
          exp_q.delete();
          $display("g%0d run %0d: %0d pixels, reset at col=%0d row=%0d", gi, s, k, got.col,
                   got.row);
          rst_n_v[gi] = 1'b0;
          #1;
          n_chk++;
          if (got != reset_obs(SAL)) begin
            n_err++;
            $display("FAIL g%0d async_reset: got %h before next edge, required %h", gi, got,
                     reset_obs(SAL));
          end
          repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        done[gi] = 1'b1;
      end
    end
  endgenerate

  // Bounded wait for all three configurations, then the summary.
  initial begin
    bit all_done;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = done[0] && done[1] && done[2];
    end
    if (!all_done) begin
      n_chk++;
      n_err++;
      $display("FAIL timeout: runs done=%b%b%b, required 111", done[0], done[1], done[2]);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster scan that every sprite, number and background renderer in the game consumes: the visible flag, the 10-bit col/row coordinates, hsync/vsync, and per-pixel, per-line and per-frame strobes.
- Runs from the system clock. An internal divider produces one pixel every CLK_DIV clocks. The default timing is 640x480 @ 60 Hz (25 MHz pixel rate from a 50 MHz clock).
- All outputs are registered, so coordinates, syncs and visible stay mutually aligned.

Parameters:
- CLK_DIV, 2: system clocks per pixel; must be >= 1.
- H_VISIBLE, 640: active pixels per line.
- H_FRONT, 16: horizontal front porch, in pixels.
- H_SYNC, 96: hsync pulse width, in pixels.
- H_BACK, 48: horizontal back porch, in pixels.
- V_VISIBLE, 480: active lines per frame.
- V_FRONT, 10: vertical front porch, in lines.
- V_SYNC, 2: vsync pulse width, in lines.
- V_BACK, 33: vertical back porch, in lines.
- SYNC_ACTIVE_LOW, 1: 1 means hsync/vsync are low during the sync pulse; 0 means high.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- pix_stb  output  1  one-clock pulse; col/row/visible/syncs hold new pixel values in this cycle.
- visible  output  1  current pixel is inside the active area.
- col  output  10  horizontal position, 0..H_TOTAL-1.
- row  output  10  vertical position, 0..V_TOTAL-1.
- hsync  output  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW.
- vsync  output  1  vertical sync, polarity set by SYNC_ACTIVE_LOW.
- line_start  output  1  one-clock pulse with the pix_stb where col==0.
- frame_start  output  1  one-clock pulse with the pix_stb where col==0 and row==0.

Behaviour:
- Derived constants: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
- Elaboration must fail if H_TOTAL > 1024, V_TOTAL > 1024, or CLK_DIV < 1.
- Reset is asynchronous: clk and rst_n only, no synchronous clear.
- Reset values:
  - div_cnt, h_cnt, v_cnt = 0.
  - col = row = 0; visible = 0.
  - hsync = vsync = inactive level.
  - pix_stb, line_start, frame_start = 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - The internal tick is high when div_cnt == CLK_DIV-1.
  - With CLK_DIV=1 the tick is high every clock.
- On each tick, in one clock edge:
  - Output registers load a decode of the current (h_cnt, v_cnt):
    - col = h_cnt; row = v_cnt.
    - visible = (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE).
    - hsync active iff H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
    - vsync active iff V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC.
    - pix_stb = 1; line_start = (h_cnt == 0); frame_start = (h_cnt == 0 and v_cnt == 0).
  - Counters then advance:
    - h_cnt increments.
    - When h_cnt == H_TOTAL-1 it wraps to 0 and v_cnt increments.
    - When v_cnt == V_TOTAL-1 at the same point, v_cnt wraps to 0.
- On a non-tick clock:
  - pix_stb, line_start and frame_start go to 0.
  - All other outputs hold.
  - With CLK_DIV=1, pix_stb stays high continuously after the first tick.
- Latency:
  - Outputs show counter state from before the edge, one tick behind the counters.
  - The first tick after reset release presents col=0, row=0, visible=1, frame_start=1.
  - With CLK_DIV=2, that tick falls on the second clock after release.
- Vsync changes only in the pix_stb cycle where col==0, never mid-line.
- Reset mid-frame: outputs return to reset values immediately, without waiting for a clock. The scan restarts at (0,0) after release; no partial-frame resumption.

Decomposition:
- Package vga_pkg:
  - Default 640x480 timing constants and derived H_TOTAL/V_TOTAL.
  - typedef coord_t (logic [9:0]), shared with all sprite renderers.
- One sub-module, vga_axis_counter:
  - Parameterized count with wrap, taking an enable and producing a carry.
  - Instantiated twice: horizontal (enable = tick) and vertical (enable = horizontal carry).
- Sync/visible decode and output registers stay in the top module.

Test Plan:
- Reset release, CLK_DIV=2:
  - Before the first tick, all outputs are at reset values and hsync=vsync=1.
  - The first pix_stb arrives on the 2nd clock with col=0, row=0, visible=1, frame_start=1.
- Line timing, CLK_DIV=2:
  - 800 pix_stb and 1600 clocks between consecutive line_start.
  - hsync low for exactly 96 pix_stb, col 656..751.
  - visible high for col 0..639.
- Wrap:
  - (col=799,row=10) is followed by (0,11) with line_start=1 and frame_start=0.
  - (799,524) is followed by (0,0) with frame_start=1.
- Frame timing:
  - 525 line_start per frame_start.
  - vsync low only for rows 490..491.
  - Exactly 307200 visible pix_stb per frame.
- Async reset mid-frame, at col=300, row=200:
  - Outputs clear in the same cycle, before the next clk edge.
  - After release, the scan restarts at (0,0).
- CLK_DIV=1, SYNC_ACTIVE_LOW=0:
  - pix_stb stays high continuously; line period is 800 clocks.
  - hsync high for col 656..751 and low elsewhere.
